shift_reg_serial: RTL and testbench
===================================

Name: shift_reg_serial

Overview:
- Serial-in, parallel-out shift register on a single clock domain.
- Each clock captures one serial bit `din` into the LSB and moves existing contents one place toward the MSB.
- The full register is presented on `q`.
- Used as a basic serial-to-parallel front end, e.g. collecting bit streams before word-level logic.

Parameters:
- WIDTH, 4, number of register stages and width of `q` (legal range 2..64).
- SHIFT_LEFT, 1, 1 = `din` enters `q[0]` and shifts toward `q[WIDTH-1]`; 0 = `din` enters `q[WIDTH-1]` and shifts toward `q[0]`.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into the register on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  1  serial data in, sampled on rising edge of clk.
- q  output  WIDTH  parallel register contents, driven directly from flops.

Behaviour:
- One clock (`clk`); reset is synchronous and active-high (`rst`). No asynchronous paths.
- Reset: when `rst`=1 at a rising edge, `q` <= RESET_VALUE (default 4'b0000). `rst` dominates `din`; the `din` bit sampled in that cycle is discarded.
- Shift, SHIFT_LEFT=1: `q` <= {`q`[WIDTH-2:0], `din`} every edge with `rst`=0.
- Shift, SHIFT_LEFT=0: `q` <= {`din`, `q`[WIDTH-1:1]} every edge with `rst`=0.
- No enable: the register shifts on every non-reset clock edge.
- Latency: a `din` bit appears at the entry stage 1 cycle after sampling and reaches the far stage after WIDTH cycles. The oldest bit falls off the far end and is lost.
- `q` is registered. It changes only at rising edges and holds its value between edges.
- Power-up, before the first reset edge: flops initialise to RESET_VALUE where the target supports initial values. Otherwise the value is undefined until the first reset.
- Reset mid-operation: a single reset edge clears the whole register. Shifting resumes on the next edge after `rst` falls.
- `rst` held high for many cycles: `q` stays at RESET_VALUE.
- X on `din`: propagates into the entry stage only. No other stage is affected that cycle.

Optional Feature:
- Macro: SHIFT_REG_SERIAL_DIN_SYNC_EN.
- Defined:
  - `din` passes through a 2-flop synchronizer clocked by `clk` before the entry stage.
  - Synchronizer flops reset to 0 on `rst`.
  - Total latency from `din` to the entry stage becomes 3 cycles.
- Undefined: `din` feeds the entry stage directly, with 1-cycle latency.
- `q` width, reset value and shift rule are identical in both builds.

Decomposition:
- Shared package shift_reg_pkg:
  - SHIFT_REG_DEFAULT_WIDTH = 4.
  - SHIFT_DIR_LEFT = 1'b1 and SHIFT_DIR_RIGHT = 1'b0 constants.
  - A function computing the next register value from (current value, `din`, direction).
- One natural sub-module, shift_reg_din_sync: 2-flop synchronizer, instantiated only under SHIFT_REG_SERIAL_DIN_SYNC_EN.
- The shift core stays in the top module.

Test Plan:
1. Reset: clk period 20 ns; `rst`=1, `din`=1 for 2 edges -> `q`=4'b0000 after each edge.
2. Fill with ones, default build: release `rst`, hold `din`=1 -> `q` = 0001, 0011, 0111, 1111 on edges 1..4, then stays 1111.
3. Pattern, default build:
   - Stimulus: after reset, drive `din` 1,0,1,1 on successive edges.
   - Required: `q`=1011 after edge 4.
   - Continuing `din`=0 gives 0110, 1100, 1000, 0000.
4. Reset mid-stream: with `q`=0111, assert `rst` for one edge while `din`=1 -> `q`=0000. Next edge with `rst`=0, `din`=1 -> `q`=0001.
5. Parameter variants:
   - WIDTH=8, SHIFT_LEFT=0: after reset, a single `din`=1 pulse followed by zeros -> `q`=8'h80, 8'h40, ... 8'h01, then 8'h00.
   - RESET_VALUE=8'hA5 -> `q`=8'hA5 after reset.
6. SHIFT_REG_SERIAL_DIN_SYNC_EN defined: after reset, `din` 0->1 held -> `q`[0] rises on the 3rd edge after `din` is first sampled high. `q`=1111 after the 6th edge.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the serial-in, parallel-out shift register.
// Contents:
//   SHIFT_REG_DEFAULT_WIDTH - default number of stages
//   SHIFT_DIR_LEFT/RIGHT    - shift direction encodings
//   shift_next()            - next register value from (current, din, direction)
package shift_reg_pkg;

  localparam int SHIFT_REG_DEFAULT_WIDTH = 4;

  localparam logic SHIFT_DIR_LEFT  = 1'b1;
  localparam logic SHIFT_DIR_RIGHT = 1'b0;

  // Operates on a 64-bit container so any legal width (2..64) fits.
  // Bits at or above `width` in the result are don't-care; callers keep
  // only the low `width` bits. `cur` must be zero above `width`.
  function automatic logic [63:0] shift_next(
    input logic [63:0] cur,
    input logic        din,
    input logic        dir,
    input int unsigned width
  );
    logic [63:0] nxt;
    logic [5:0]  msb;
    msb = 6'(width - 32'd1);
    if (dir == SHIFT_DIR_LEFT) begin
      nxt = {cur[62:0], din};
    end else begin
      nxt      = {1'b0, cur[63:1]};
      nxt[msb] = din;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/shift_reg_serial_if.sv
// Data bundle between a serial bit source and the shift register.
// Signals:
//   din - serial data bit (source -> register)
//   q   - parallel register contents, WIDTH bits (register -> consumer)
// Modports: master = source/consumer side, slave = shift register side.
// WIDTH must match the WIDTH of the shift_reg_serial it is connected to.
interface shift_reg_serial_if
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = SHIFT_REG_DEFAULT_WIDTH
);
  logic             din;
  logic [WIDTH-1:0] q;

  modport master (output din, input q);
  modport slave  (input din, output q);
endinterface

// File: rtl/shift_reg_din_sync.sv
// Two-flop synchronizer for the serial input bit.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset, clears both stages to 0
//   din      - raw (possibly asynchronous) serial bit
//   din_sync - bit delayed by two clocks, safe to use in the clk domain
module shift_reg_din_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic din_sync
);

  logic meta_r;
  logic sync_r;

  // Two back-to-back capture stages; the first may go metastable.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
    end
  end

  assign din_sync = sync_r;

endmodule

// File: rtl/shift_reg_serial.sv
// Serial-in, parallel-out shift register.
// Every non-reset rising edge captures one serial bit into the entry stage
// and moves the rest one place toward the far stage; the oldest bit is lost.
// Parameters:
//   WIDTH       - number of stages / width of q (2..64)
//   SHIFT_LEFT  - 1: din enters q[0], moves toward q[WIDTH-1]
//                 0: din enters q[WIDTH-1], moves toward q[0]
//   RESET_VALUE - value loaded on reset
// Ports:
//   clk - clock, rising edge
//   rst - synchronous active-high reset, dominates din
//   bus - shift_reg_serial_if.slave: din in, q out (q straight from flops)
// Build option SHIFT_REG_SERIAL_DIN_SYNC_EN: when defined, din passes
// through a 2-flop synchronizer first (3-cycle din-to-entry latency instead
// of 1). Width, reset value and shift rule are the same in both builds.
module shift_reg_serial
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH       = SHIFT_REG_DEFAULT_WIDTH,
  parameter bit               SHIFT_LEFT  = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input logic               clk,
  input logic               rst,
  shift_reg_serial_if.slave bus
);

  logic             entry_s;
  logic [63:0]      cur_s;
  logic [WIDTH-1:0] next_s;
  logic [WIDTH-1:0] q_r;

`ifdef SHIFT_REG_SERIAL_DIN_SYNC_EN
  shift_reg_din_sync u_din_sync (
    .clk      (clk),
    .rst      (rst),
    .din      (bus.din),
    .din_sync (entry_s)
  );
`else
  assign entry_s = bus.din;
`endif

  // Widen the register into the helper's 64-bit container and keep only
  // the live WIDTH bits of the result.
  always_comb begin
    cur_s            = 64'd0;
    cur_s[WIDTH-1:0] = q_r;
    next_s = WIDTH'(shift_next(cur_s, entry_s, logic'(SHIFT_LEFT), 32'(WIDTH)));
  end

  // Shift on every edge; reset wins over din.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= RESET_VALUE;
    end else begin
      q_r <= next_s;
    end
  end

  assign bus.q = q_r;

endmodule

// File: tb/tb_shift_reg_serial.sv
module tb_shift_reg_serial;

  logic clk;
  logic rst;
  logic din;

  int errors;
  int checks;

  // Reference model state (8-bit containers, upper bits unused for width 4).
  logic [7:0] m4;
  logic [7:0] m8r;
  logic [7:0] m8v;
  logic       s1;
  logic       s2;

  logic [7:0] sb4[$];
  logic [7:0] sb8r[$];
  logic [7:0] sb8v[$];

  shift_reg_serial_if #(.WIDTH(4)) bus4 ();
  shift_reg_serial_if #(.WIDTH(8)) bus8r ();
  shift_reg_serial_if #(.WIDTH(8)) bus8v ();

  assign bus4.din  = din;
  assign bus8r.din = din;
  assign bus8v.din = din;

  shift_reg_serial #(.WIDTH(4), .SHIFT_LEFT(1'b1), .RESET_VALUE(4'b0000)) dut4 (
    .clk (clk), .rst (rst), .bus (bus4)
  );
  shift_reg_serial #(.WIDTH(8), .SHIFT_LEFT(1'b0), .RESET_VALUE(8'h00)) dut8r (
    .clk (clk), .rst (rst), .bus (bus8r)
  );
  shift_reg_serial #(.WIDTH(8), .SHIFT_LEFT(1'b1), .RESET_VALUE(8'hA5)) dut8v (
    .clk (clk), .rst (rst), .bus (bus8v)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] mshift(input logic [7:0] cur, input logic b,
                                        input int w, input bit left);
    logic [7:0] r;
    r = 8'h00;
    if (left) begin
      for (int i = 1; i < w; i++) r[i] = cur[i-1];
      r[0] = b;
    end else begin
      for (int i = 0; i < w - 1; i++) r[i] = cur[i+1];
      r[w-1] = b;
    end
    return r;
  endfunction

  // Drive one cycle, push the model's expectation, then compare after the edge.
  task automatic step(input logic r, input logic d);
    logic e;
    @(negedge clk);
    rst = r;
    din = d;
`ifdef SHIFT_REG_SERIAL_DIN_SYNC_EN
    e = s2;
    if (r) begin
      s1 = 1'b0;
      s2 = 1'b0;
    end else begin
      s2 = s1;
      s1 = d;
    end
`else
    e = d;
`endif
    if (r) begin
      m4  = 8'h00;
      m8r = 8'h00;
      m8v = 8'hA5;
    end else begin
      m4  = mshift(m4, e, 4, 1'b1);
      m8r = mshift(m8r, e, 8, 1'b0);
      m8v = mshift(m8v, e, 8, 1'b1);
    end
    sb4.push_back(m4);
    sb8r.push_back(m8r);
    sb8v.push_back(m8v);
    @(posedge clk);
    #1;
    check_val("q4",   {60'd0, bus4.q},  {56'd0, sb4.pop_front()});
    check_val("q8r",  {56'd0, bus8r.q}, {56'd0, sb8r.pop_front()});
    check_val("q8rv", {56'd0, bus8v.q}, {56'd0, sb8v.pop_front()});
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    din = 1'b1;
    m4 = 8'h00; m8r = 8'h00; m8v = 8'hA5;
    s1 = 1'b0;  s2 = 1'b0;

    // Reset held with din=1.
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check_val("rst_q4", {60'd0, bus4.q}, 64'h0);
    check_val("rst_val_a5", {56'd0, bus8v.q}, 64'hA5);

    // Fill with ones.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
`ifndef SHIFT_REG_SERIAL_DIN_SYNC_EN
    check_val("fill_q4", {60'd0, bus4.q}, 64'hF);
`endif

    // Pattern 1,0,1,1 then zeros.
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
`ifndef SHIFT_REG_SERIAL_DIN_SYNC_EN
    check_val("pat_q4", {60'd0, bus4.q}, 64'hB);
`endif
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
`ifndef SHIFT_REG_SERIAL_DIN_SYNC_EN
    check_val("pat_drain_q4", {60'd0, bus4.q}, 64'h0);
`endif

    // Reset mid-stream.
    step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
`ifndef SHIFT_REG_SERIAL_DIN_SYNC_EN
    check_val("mid_pre_q4", {60'd0, bus4.q}, 64'h7);
`endif
    step(1'b1, 1'b1);
    check_val("mid_rst_q4", {60'd0, bus4.q}, 64'h0);
    step(1'b0, 1'b1);
`ifndef SHIFT_REG_SERIAL_DIN_SYNC_EN
    check_val("mid_post_q4", {60'd0, bus4.q}, 64'h1);
`endif

    // Single pulse through the 8-bit right-shifting instance.
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
`ifndef SHIFT_REG_SERIAL_DIN_SYNC_EN
    check_val("pulse_first", {56'd0, bus8r.q}, 64'h80);
`endif
    for (int i = 0; i < 11; i++) step(1'b0, 1'b0);
    check_val("pulse_gone", {56'd0, bus8r.q}, 64'h00);

    // din 0 then held 1: entry-stage latency.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
`ifdef SHIFT_REG_SERIAL_DIN_SYNC_EN
    step(1'b0, 1'b1);
    check_val("sync_lat2", {63'd0, bus4.q[0]}, 64'h0);
    step(1'b0, 1'b1);
    check_val("sync_lat3", {63'd0, bus4.q[0]}, 64'h1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    check_val("sync_full", {60'd0, bus4.q}, 64'hF);
`else
    check_val("lat1", {63'd0, bus4.q[0]}, 64'h1);
`endif

    // Random stream with occasional resets.
    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
